led_blink_decoder: RTL

// Receive-side counterpart of the LED blinker: samples a blink line and recovers which blink

---
 rtl/led_blink_decoder.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/led_blink_decoder.sv
// led_blink_decoder: recovers the blink-rate code (100/50/10/1 Hz) from a
// sampled LED line by measuring half-periods between edges, locking after
// c_LOCK_N consistent matches and flagging a static line as inactive.
// Optional feature: define LED_DECODE_PERIOD_OUT_EN to add o_period, the last
// measured half-period in clocks.
module led_blink_decoder #(
    parameter int unsigned c_CNT_100HZ = 125,
    parameter int unsigned c_CNT_50HZ  = 250,
    parameter int unsigned c_CNT_10HZ  = 1250,
    parameter int unsigned c_CNT_1HZ   = 12500,
    parameter int unsigned c_TOL_SHIFT = 3,
    parameter int unsigned c_LOCK_N    = 4,
    parameter int unsigned c_TIMEOUT   = 25000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_led,
    output logic [1:0]  o_code,
    output logic        o_valid,
    output logic        o_active,
    output logic        o_error
`ifdef LED_DECODE_PERIOD_OUT_EN
    ,
    output logic [31:0] o_period
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_ACQUIRE,
        S_LOCKED
    } state_t;

    state_t      r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_sync2_d;
    logic        r_edge;
    logic [31:0] r_cnt;
    logic [31:0] r_match;
    logic [1:0]  r_cand;
    logic [1:0]  r_code;
    logic        r_valid;
    logic        r_active;
    logic        r_error;
`ifdef LED_DECODE_PERIOD_OUT_EN
    logic [31:0] r_period;
`endif

    logic [31:0] w_h;
    logic        w_cls_ok;
    logic [1:0]  w_cls;
    logic        w_timeout;

    // Inclusive window test: |h - nom| <= nom >> c_TOL_SHIFT
    function automatic logic f_in_win(input logic [31:0] h, input int unsigned nom);
        logic [31:0] v_nom;
        logic [31:0] v_tol;
        v_nom = 32'(nom);
        v_tol = 32'(nom >> c_TOL_SHIFT);
        return (h >= (v_nom - v_tol)) && (h <= (v_nom + v_tol));
    endfunction

    // Two-flop synchronizer followed by a registered either-polarity edge detect
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync2_d <= 1'b0;
            r_edge    <= 1'b0;
        end else begin
            r_sync1   <= i_led;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
            r_edge    <= r_sync2 ^ r_sync2_d;
        end
    end

    // Half-period counter: cleared by an edge, otherwise counts up to c_TIMEOUT and holds
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (r_edge) begin
            r_cnt <= '0;
        end else if (r_cnt != 32'(c_TIMEOUT)) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    // Classify the half-period ending at this cycle's edge (windows do not overlap)
    always_comb begin
        w_h       = r_cnt + 32'd1;
        w_timeout = (r_cnt == 32'(c_TIMEOUT));
        w_cls_ok  = 1'b1;
        w_cls     = 2'b00;
        if (f_in_win(w_h, c_CNT_100HZ)) begin
            w_cls = 2'b00;
        end else if (f_in_win(w_h, c_CNT_50HZ)) begin
            w_cls = 2'b01;
        end else if (f_in_win(w_h, c_CNT_10HZ)) begin
            w_cls = 2'b10;
        end else if (f_in_win(w_h, c_CNT_1HZ)) begin
            w_cls = 2'b11;
        end else begin
            w_cls_ok = 1'b0;
        end
    end

    // Lock FSM with registered outputs; a timeout can only occur on a non-edge cycle
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_match  <= '0;
            r_cand   <= 2'b00;
            r_code   <= 2'b00;
            r_valid  <= 1'b0;
            r_active <= 1'b0;
            r_error  <= 1'b0;
`ifdef LED_DECODE_PERIOD_OUT_EN
            r_period <= '0;
`endif
        end else begin
            r_error <= 1'b0;
            if (r_edge) begin
                r_active <= 1'b1;
`ifdef LED_DECODE_PERIOD_OUT_EN
                if (r_state != S_IDLE) begin
                    r_period <= w_h;
                end
`endif
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_ARMED;
                    end
                    S_ARMED: begin
                        if (w_cls_ok) begin
                            r_cand  <= w_cls;
                            r_match <= 32'd1;
                            if (c_LOCK_N <= 1) begin
                                r_state <= S_LOCKED;
                                r_valid <= 1'b1;
                                r_code  <= w_cls;
                            end else begin
                                r_state <= S_ACQUIRE;
                            end
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                    S_ACQUIRE: begin
                        if (!w_cls_ok) begin
                            r_error <= 1'b1;
                            r_state <= S_ARMED;
                            r_match <= '0;
                        end else if (w_cls == r_cand) begin
                            r_match <= r_match + 32'd1;
                            if ((r_match + 32'd1) >= 32'(c_LOCK_N)) begin
                                r_state <= S_LOCKED;
                                r_valid <= 1'b1;
                                r_code  <= r_cand;
                            end
                        end else begin
                            r_cand  <= w_cls;
                            r_match <= 32'd1;
                            if (c_LOCK_N <= 1) begin
                                r_state <= S_LOCKED;
                                r_valid <= 1'b1;
                                r_code  <= w_cls;
                            end
                        end
                    end
                    S_LOCKED: begin
                        if (!w_cls_ok) begin
                            r_error <= 1'b1;
                            r_state <= S_ARMED;
                            r_match <= '0;
                            r_valid <= 1'b0;
                            r_code  <= 2'b00;
                        end else if (w_cls != r_cand) begin
                            r_error <= 1'b1;
                            r_state <= S_ACQUIRE;
                            r_cand  <= w_cls;
                            r_match <= 32'd1;
                            r_valid <= 1'b0;
                            r_code  <= 2'b00;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end else if (w_timeout) begin
                r_state  <= S_IDLE;
                r_match  <= '0;
                r_valid  <= 1'b0;
                r_code   <= 2'b00;
                r_active <= 1'b0;
            end
        end
    end

    assign o_code   = r_code;
    assign o_valid  = r_valid;
    assign o_active = r_active;
    assign o_error  = r_error;
`ifdef LED_DECODE_PERIOD_OUT_EN
    assign o_period = r_period;
`endif

endmodule
